// File: rtl/udp_pkg.sv
// Shared types for the UDP payload buffer: the 9-bit RAM word {last, byte}.
package udp_pkg;

    localparam int UDP_BYTE_W = 8;

    typedef struct packed {
        logic                  last;
        logic [UDP_BYTE_W-1:0] data;
    } buf_word_t;

    localparam int BUF_WORD_W = $bits(buf_word_t);

    function automatic buf_word_t make_word(input logic last, input logic [UDP_BYTE_W-1:0] data);
        buf_word_t w;
        w.last = last;
        w.data = data;
        return w;
    endfunction

endpackage

// File: rtl/sdp_ram_sync.sv
// Simple dual-port RAM, one write and one registered read port; maps onto block RAM.
module sdp_ram_sync #(
    parameter int WIDTH  = 9,
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/udp_payload_buffer.sv
// Store-and-forward payload buffer: commits good datagrams to an AXI4-Stream master, rolls back bad ones.
// Optional saturating frame statistics are built when UDP_PAYLOAD_STATS_EN is defined.
module udp_payload_buffer
    import udp_pkg::*;
#(
    parameter int DEPTH  = 2048,
    parameter int STAT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [UDP_BYTE_W-1:0] udp_data_in,
    input  logic                  udp_byte_valid,
    input  logic                  udp_eof,
    input  logic                  udp_err,
    output logic [UDP_BYTE_W-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  frame_commit,
    output logic                  frame_drop
`ifdef UDP_PAYLOAD_STATS_EN
    ,
    output logic [STAT_W-1:0]     stat_ok_cnt,
    output logic [STAT_W-1:0]     stat_drop_cnt
`endif
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_PTR = PTR_W'(DEPTH);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      commit_ptr_q, commit_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      fetch_ptr_q, fetch_ptr_d;
    logic                  stage_valid_q, stage_valid_d;
    logic [UDP_BYTE_W-1:0] stage_data_q, stage_data_d;
    logic                  eof_pend_q, eof_pend_d;
    logic                  ovf_q, ovf_d;
    logic                  frame_commit_q, frame_commit_d;
    logic                  frame_drop_q, frame_drop_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            cnt_q, cnt_d;
    buf_word_t             ent0_q, ent0_d;
    buf_word_t             ent1_q, ent1_d;

    logic                  full;
    logic                  end_write;
    logic                  mid_write;
    logic                  ovf_now;
    logic                  ram_we;
    logic [BUF_WORD_W-1:0] ram_wdata;
    logic                  ram_re;
    logic [BUF_WORD_W-1:0] ram_rdata;
    logic                  pop;
    logic [2:0]            occ;

    sdp_ram_sync #(
        .WIDTH (BUF_WORD_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(wr_ptr_q[ADDR_W-1:0]),
        .wdata(ram_wdata),
        .re   (ram_re),
        .raddr(fetch_ptr_q[ADDR_W-1:0]),
        .rdata(ram_rdata)
    );

    // eof_pend marks the staged byte as the frame's last one (byte and eof arrived together).
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        commit_ptr_d   = commit_ptr_q;
        stage_valid_d  = stage_valid_q;
        stage_data_d   = stage_data_q;
        eof_pend_d     = eof_pend_q;
        ovf_d          = ovf_q;
        frame_commit_d = 1'b0;
        frame_drop_d   = 1'b0;
        ram_we         = 1'b0;
        ram_wdata      = '0;
        end_write      = 1'b0;
        mid_write      = 1'b0;
        ovf_now        = 1'b0;
        full           = ((wr_ptr_q - rd_ptr_q) == DEPTH_PTR);

        if (udp_err) begin
            wr_ptr_d      = commit_ptr_q;
            stage_valid_d = 1'b0;
            eof_pend_d    = 1'b0;
            ovf_d         = 1'b0;
            frame_drop_d  = 1'b1;
        end else begin
            end_write = eof_pend_q || (udp_eof && !udp_byte_valid && stage_valid_q);
            mid_write = !end_write && udp_byte_valid && stage_valid_q;
            ovf_now   = ovf_q || ((end_write || mid_write) && full);

            if ((end_write || mid_write) && !ovf_now) begin
                ram_we    = 1'b1;
                ram_wdata = make_word(end_write, stage_data_q);
                wr_ptr_d  = wr_ptr_q + 1'b1;
            end

            if (end_write) begin
                ovf_d = 1'b0;
                if (ovf_now) begin
                    wr_ptr_d     = commit_ptr_q;
                    frame_drop_d = 1'b1;
                end else begin
                    commit_ptr_d   = wr_ptr_q + 1'b1;
                    frame_commit_d = 1'b1;
                end
            end else begin
                ovf_d = ovf_now;
            end

            if (udp_byte_valid) begin
                stage_valid_d = 1'b1;
                stage_data_d  = udp_data_in;
                eof_pend_d    = udp_eof;
            end else if (end_write) begin
                stage_valid_d = 1'b0;
                eof_pend_d    = 1'b0;
            end

            // An eof with nothing staged (beyond a pending last byte) is an empty frame.
            if (udp_eof && !udp_byte_valid && (eof_pend_q || !stage_valid_q)) begin
                frame_drop_d = 1'b1;
                if (ovf_q && !end_write) begin
                    wr_ptr_d = commit_ptr_q;
                    ovf_d    = 1'b0;
                end
            end
        end
    end

    // Two-entry skid: a fetch is issued only if its word will have room when it lands.
    always_comb begin
        fetch_ptr_d = fetch_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ent0_d      = ent0_q;
        ent1_d      = ent1_q;
        pop         = (cnt_q != 2'd0) && m_axis_tready;
        occ         = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        ram_re      = (fetch_ptr_q != commit_ptr_q) && (occ <= 3'd1);
        inflight_d  = ram_re;
        cnt_d       = occ[1:0];

        if (ram_re) begin
            fetch_ptr_d = fetch_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({inflight_q, pop})
            2'b01: ent0_d = ent1_q;
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    ent0_d = buf_word_t'(ram_rdata);
                end else begin
                    ent1_d = buf_word_t'(ram_rdata);
                end
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    ent0_d = buf_word_t'(ram_rdata);
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = buf_word_t'(ram_rdata);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            commit_ptr_q   <= '0;
            rd_ptr_q       <= '0;
            fetch_ptr_q    <= '0;
            stage_valid_q  <= 1'b0;
            stage_data_q   <= '0;
            eof_pend_q     <= 1'b0;
            ovf_q          <= 1'b0;
            frame_commit_q <= 1'b0;
            frame_drop_q   <= 1'b0;
            inflight_q     <= 1'b0;
            cnt_q          <= 2'd0;
            ent0_q         <= '0;
            ent1_q         <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            commit_ptr_q   <= commit_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fetch_ptr_q    <= fetch_ptr_d;
            stage_valid_q  <= stage_valid_d;
            stage_data_q   <= stage_data_d;
            eof_pend_q     <= eof_pend_d;
            ovf_q          <= ovf_d;
            frame_commit_q <= frame_commit_d;
            frame_drop_q   <= frame_drop_d;
            inflight_q     <= inflight_d;
            cnt_q          <= cnt_d;
            ent0_q         <= ent0_d;
            ent1_q         <= ent1_d;
        end
    end

    assign m_axis_tdata  = ent0_q.data;
    assign m_axis_tlast  = ent0_q.last;
    assign m_axis_tvalid = (cnt_q != 2'd0);
    assign frame_commit  = frame_commit_q;
    assign frame_drop    = frame_drop_q;

`ifdef UDP_PAYLOAD_STATS_EN
    logic [STAT_W-1:0] stat_ok_q, stat_ok_d;
    logic [STAT_W-1:0] stat_drop_q, stat_drop_d;

    always_comb begin
        stat_ok_d   = stat_ok_q;
        stat_drop_d = stat_drop_q;
        if (frame_commit_q && (stat_ok_q != '1)) begin
            stat_ok_d = stat_ok_q + 1'b1;
        end
        if (frame_drop_q && (stat_drop_q != '1)) begin
            stat_drop_d = stat_drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ok_q   <= '0;
            stat_drop_q <= '0;
        end else begin
            stat_ok_q   <= stat_ok_d;
            stat_drop_q <= stat_drop_d;
        end
    end

    assign stat_ok_cnt   = stat_ok_q;
    assign stat_drop_cnt = stat_drop_q;
`endif

endmodule

// File: tb/tb_udp_payload_buffer.sv
// Directed bench for udp_payload_buffer: good/err/overflow/empty frames, random backpressure, mid-frame reset.
module tb_udp_payload_buffer;

    localparam int DEPTH  = 64;
    localparam int STAT_W = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] udp_data_in = '0;
    logic       udp_byte_valid = 1'b0;
    logic       udp_eof = 1'b0;
    logic       udp_err = 1'b0;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b0;
    logic       m_axis_tlast;
    logic       frame_commit;
    logic       frame_drop;
`ifdef UDP_PAYLOAD_STATS_EN
    logic [STAT_W-1:0] stat_ok_cnt;
    logic [STAT_W-1:0] stat_drop_cnt;
`endif

    always #5 clk = ~clk;

    udp_payload_buffer #(
        .DEPTH (DEPTH),
        .STAT_W(STAT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .udp_data_in   (udp_data_in),
        .udp_byte_valid(udp_byte_valid),
        .udp_eof       (udp_eof),
        .udp_err       (udp_err),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .frame_commit  (frame_commit),
        .frame_drop    (frame_drop)
`ifdef UDP_PAYLOAD_STATS_EN
        ,
        .stat_ok_cnt   (stat_ok_cnt),
        .stat_drop_cnt (stat_drop_cnt)
`endif
    );

    int   errors = 0;
    int   checks = 0;
    logic [7:0] sb_data[$];
    logic       sb_last[$];
    bit   rand_ready = 0;

    int   cyc = 0;
    int   commit_cnt = 0;
    int   drop_cnt = 0;
    int   beat_cnt = 0;
    int   commit_cyc = 0;
    int   first_cyc = 0;
    int   last_span = 0;
    int   last_latency = 0;
    bit   in_frame = 0;
    bit   prev_stall = 0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;
    logic [7:0] exp_data;
    logic       exp_last;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard compare, stall stability, pulse counting
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            in_frame   = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                checkOutput("stall_tvalid", m_axis_tvalid, 1);
                checkOutput("stall_tdata", m_axis_tdata, prev_data);
                checkOutput("stall_tlast", m_axis_tlast, prev_last);
            end
            if (frame_commit) begin
                commit_cnt++;
                commit_cyc = cyc;
            end
            if (frame_drop) drop_cnt++;
            if (m_axis_tvalid && m_axis_tready) begin
                beat_cnt++;
                checkOutput("beat_expected", sb_data.size() != 0, 1);
                if (sb_data.size() != 0) begin
                    exp_data = sb_data.pop_front();
                    exp_last = sb_last.pop_front();
                    checkOutput("beat_tdata", m_axis_tdata, exp_data);
                    checkOutput("beat_tlast", m_axis_tlast, exp_last);
                end
                if (!in_frame) begin
                    in_frame     = 1;
                    first_cyc    = cyc;
                    last_latency = cyc - commit_cyc;
                end
                if (m_axis_tlast) begin
                    in_frame  = 0;
                    last_span = cyc - first_cyc + 1;
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic eof, input logic err);
        udp_byte_valid = v;
        udp_data_in    = d;
        udp_eof        = eof;
        udp_err        = err;
        if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        udp_byte_valid = 1'b0;
        udp_eof        = 1'b0;
        udp_err        = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // mode 0: eof with last byte, 1: eof one cycle later, 2: no end (caller terminates)
    task automatic sendFrame(input int len, input logic [7:0] base, input int mode, input bit rnd);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            b = rnd ? 8'($urandom) : base + 8'(i);
            if (mode != 2) begin
                sb_data.push_back(b);
                sb_last.push_back(i == len - 1);
            end
            applyStimulus(1'b1, b, (mode == 0) && (i == len - 1), 1'b0);
        end
        if (mode == 1) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic waitDrain(input int max_cycles, input string tag);
        int n = 0;
        while (sb_data.size() != 0 && n < max_cycles) begin
            idle(1);
            n++;
        end
        checkOutput(tag, sb_data.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int c0, d0, b0, c_rst, d_rst, len, n;

        idle(3);
        checkOutput("rst_tvalid", m_axis_tvalid, 0);
        checkOutput("rst_tdata", m_axis_tdata, 0);
        checkOutput("rst_tlast", m_axis_tlast, 0);
        checkOutput("rst_commit", frame_commit, 0);
        checkOutput("rst_drop", frame_drop, 0);
        rst_n = 1'b1;
        idle(2);

        // 01..08 with eof on the last byte, consumer always ready
        m_axis_tready = 1'b1;
        c0 = commit_cnt;
        sendFrame(8, 8'h01, 0, 0);
        waitDrain(30, "t1_drain");
        idle(2);
        checkOutput("t1_commits", commit_cnt - c0, 1);
        checkOutput("t1_span_no_bubbles", last_span, 8);
        checkOutput("t1_latency_le3", last_latency <= 3, 1);

        // AA,BB,CC with eof one cycle after CC
        c0 = commit_cnt;
        sb_data.push_back(8'hAA); sb_last.push_back(1'b0);
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
        sb_data.push_back(8'hBB); sb_last.push_back(1'b0);
        applyStimulus(1'b1, 8'hBB, 1'b0, 1'b0);
        sb_data.push_back(8'hCC); sb_last.push_back(1'b1);
        applyStimulus(1'b1, 8'hCC, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        waitDrain(30, "t2_drain");
        idle(2);
        checkOutput("t2_commits", commit_cnt - c0, 1);
        checkOutput("t2_span", last_span, 3);

        // 10-byte frame killed by err (byte with err ignored), then a good 3-byte frame
        c0 = commit_cnt; d0 = drop_cnt;
        sendFrame(10, 8'h30, 2, 0);
        applyStimulus(1'b1, 8'h3F, 1'b0, 1'b1);
        sendFrame(3, 8'h50, 0, 0);
        waitDrain(30, "t3_drain");
        idle(2);
        checkOutput("t3_drops", drop_cnt - d0, 1);
        checkOutput("t3_commits", commit_cnt - c0, 1);

        // empty frame: eof with nothing staged
        c0 = commit_cnt; d0 = drop_cnt; b0 = beat_cnt;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        idle(4);
        checkOutput("t4_empty_drop", drop_cnt - d0, 1);
        checkOutput("t4_empty_nocommit", commit_cnt - c0, 0);
        checkOutput("t4_empty_nobeats", beat_cnt - b0, 0);

        // overflow: 70 bytes into a 64-byte buffer, consumer stalled
        m_axis_tready = 1'b0;
        c0 = commit_cnt; d0 = drop_cnt;
        sendFrame(70, 8'h00, 2, 0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        idle(3);
        checkOutput("t5_ovf_drop", drop_cnt - d0, 1);
        checkOutput("t5_ovf_nocommit", commit_cnt - c0, 0);
        checkOutput("t5_ovf_tvalid", m_axis_tvalid, 0);
        sendFrame(4, 8'hE0, 0, 0);
        idle(6);
        checkOutput("t5_post_tvalid", m_axis_tvalid, 1);
        checkOutput("t5_post_tdata", m_axis_tdata, 8'hE0);
        m_axis_tready = 1'b1;
        waitDrain(30, "t5_drain");
        idle(2);
        checkOutput("t5_post_commit", commit_cnt - c0, 1);

        // 100 random frames under 50% backpressure
        rand_ready = 1;
        c0 = commit_cnt;
        for (int f = 0; f < 100; f++) begin
            len = $urandom_range(1, 64);
            n = 0;
            while (sb_data.size() + len > DEPTH && n < 2000) begin
                idle(1);
                n++;
            end
            if (n >= 2000) checkOutput("t6_space_wait", sb_data.size() + len <= DEPTH, 1);
            sendFrame(len, 8'h00, $urandom_range(0, 1), 1);
            idle($urandom_range(0, 2));
        end
        waitDrain(20000, "t6_drain");
        rand_ready = 0;
        m_axis_tready = 1'b1;
        idle(3);
        checkOutput("t6_commits", commit_cnt - c0, 100);

        // reset mid-frame with one committed frame unread
        m_axis_tready = 1'b0;
        sendFrame(5, 8'h70, 0, 0);
        idle(5);
        checkOutput("t7_pre_tvalid", m_axis_tvalid, 1);
        applyStimulus(1'b1, 8'h81, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h82, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("t7_rst_tvalid", m_axis_tvalid, 0);
        checkOutput("t7_rst_commit", frame_commit, 0);
        sb_data.delete();
        sb_last.delete();
        idle(2);
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        b0 = beat_cnt; c_rst = commit_cnt; d_rst = drop_cnt;
        idle(10);
        checkOutput("t7_no_stale_beats", beat_cnt - b0, 0);
        sendFrame(2, 8'h90, 1, 0);
        waitDrain(30, "t7_drain");
        idle(3);
        checkOutput("t7_post_commit", commit_cnt - c_rst, 1);
`ifdef UDP_PAYLOAD_STATS_EN
        checkOutput("stat_ok", stat_ok_cnt, commit_cnt - c_rst);
        checkOutput("stat_drop", stat_drop_cnt, drop_cnt - d_rst);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
